// File: rtl/sram_sp_multi_bank_ctrl.sv
// Round-robin front end sharing one multi-bank SP SRAM between two ports, plus a zero-fill sequencer.
// Grant is combinational (rdy with val); read data returns 1+KNOB_REGOUT cycles later; responses never stall.
module sram_sp_multi_bank_ctrl #(
  parameter int KNOB_REGOUT = 0,
  parameter int NUMB_BNK    = 4,
  parameter int SIZE        = 16,
  parameter int DATA_WD     = 8,
  localparam int NUMB_BNK_WD = (NUMB_BNK > 1) ? $clog2(NUMB_BNK) : 1,
  localparam int SIZE_WD     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_clr_start_i,
  output logic                   cfg_clr_done_o,
  input  logic                   req0_val_i,
  output logic                   req0_rdy_o,
  input  logic                   req0_wr_i,
  input  logic [NUMB_BNK_WD-1:0] req0_bnk_i,
  input  logic [SIZE_WD-1:0]     req0_adr_i,
  input  logic [DATA_WD-1:0]     req0_dat_i,
  input  logic                   req1_val_i,
  output logic                   req1_rdy_o,
  input  logic                   req1_wr_i,
  input  logic [NUMB_BNK_WD-1:0] req1_bnk_i,
  input  logic [SIZE_WD-1:0]     req1_adr_i,
  input  logic [DATA_WD-1:0]     req1_dat_i,
  output logic                   rsp0_val_o,
  output logic [DATA_WD-1:0]     rsp0_dat_o,
  output logic                   rsp1_val_o,
  output logic [DATA_WD-1:0]     rsp1_dat_o,
  output logic [NUMB_BNK_WD-1:0] sram_bnk_o,
  output logic [SIZE_WD-1:0]     sram_adr_o,
  output logic                   sram_wr_val_o,
  output logic [DATA_WD-1:0]     sram_wr_dat_o,
  output logic                   sram_rd_val_o,
  input  logic                   sram_rd_val_i,
  input  logic [DATA_WD-1:0]     sram_rd_dat_i
);

  localparam int LAT = 1 + KNOB_REGOUT;
  localparam logic [NUMB_BNK_WD-1:0] BNK_LST = NUMB_BNK_WD'(NUMB_BNK - 1);
  localparam logic [SIZE_WD-1:0]     ADR_LST = SIZE_WD'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, CLR, DONE} state_t;

  state_t                   state_r, state_nxt;
  logic                     lst_r;
  logic [NUMB_BNK_WD-1:0]   bnk_cnt_r;
  logic [SIZE_WD-1:0]       adr_cnt_r;
  logic                     tag_rd_r  [LAT];
  logic                     tag_prt_r [LAT];
  logic                     gnt0, gnt1, clr_last, rsp_hit;

  // lst_r = 1 means port 1 was served last, so port 0 wins the next tie
  assign gnt0 = (state_r == IDLE) & ~rst & req0_val_i & (~req1_val_i | lst_r);
  assign gnt1 = (state_r == IDLE) & ~rst & req1_val_i & (~req0_val_i | ~lst_r);
  assign req0_rdy_o = gnt0;
  assign req1_rdy_o = gnt1;
  assign clr_last   = (bnk_cnt_r == BNK_LST) & (adr_cnt_r == ADR_LST);
  assign cfg_clr_done_o = (state_r == DONE) & ~rst;

  always_comb begin
    state_nxt     = state_r;
    sram_bnk_o    = '0;
    sram_adr_o    = '0;
    sram_wr_dat_o = '0;
    sram_wr_val_o = 1'b0;
    sram_rd_val_o = 1'b0;
    case (state_r)
      IDLE: if (cfg_clr_start_i) state_nxt = CLR;
      CLR:  if (clr_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (gnt0) begin
      sram_bnk_o    = req0_bnk_i;
      sram_adr_o    = req0_adr_i;
      sram_wr_dat_o = req0_dat_i;
      sram_wr_val_o = req0_wr_i;
      sram_rd_val_o = ~req0_wr_i;
    end else if (gnt1) begin
      sram_bnk_o    = req1_bnk_i;
      sram_adr_o    = req1_adr_i;
      sram_wr_dat_o = req1_dat_i;
      sram_wr_val_o = req1_wr_i;
      sram_rd_val_o = ~req1_wr_i;
    end else if (state_r == CLR && !rst) begin
      sram_bnk_o    = bnk_cnt_r;
      sram_adr_o    = adr_cnt_r;
      sram_wr_val_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      lst_r     <= 1'b1;
      bnk_cnt_r <= '0;
      adr_cnt_r <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_rd_r[i]  <= 1'b0;
        tag_prt_r[i] <= 1'b0;
      end
    end else begin
      state_r <= state_nxt;
      if (gnt0 | gnt1) lst_r <= gnt1;
      // counters wrap back to zero on the final write, ready for the next clear
      if (state_r == CLR) begin
        if (adr_cnt_r == ADR_LST) begin
          adr_cnt_r <= '0;
          bnk_cnt_r <= (bnk_cnt_r == BNK_LST) ? '0 : bnk_cnt_r + NUMB_BNK_WD'(1);
        end else begin
          adr_cnt_r <= adr_cnt_r + SIZE_WD'(1);
        end
      end
      for (int i = LAT - 1; i > 0; i--) begin
        tag_rd_r[i]  <= tag_rd_r[i-1];
        tag_prt_r[i] <= tag_prt_r[i-1];
      end
      tag_rd_r[0]  <= sram_rd_val_o;
      tag_prt_r[0] <= gnt1;
    end
  end

  assign rsp_hit    = sram_rd_val_i & tag_rd_r[LAT-1] & ~rst;
  assign rsp0_val_o = rsp_hit & ~tag_prt_r[LAT-1];
  assign rsp1_val_o = rsp_hit & tag_prt_r[LAT-1];
  assign rsp0_dat_o = rsp0_val_o ? sram_rd_dat_i : '0;
  assign rsp1_dat_o = rsp1_val_o ? sram_rd_dat_i : '0;

  a_req0_bnk: assert property (@(posedge clk) disable iff (rst)
    req0_val_i |-> (int'(req0_bnk_i) < NUMB_BNK));
  a_req1_bnk: assert property (@(posedge clk) disable iff (rst)
    req1_val_i |-> (int'(req1_bnk_i) < NUMB_BNK));

endmodule
